// File: rtl/cpu_defs.sv
// Shared CPU definitions for the flag/condition datapath.
//   - 4-bit condition codes (Bcond/Jcond/Scond encodings)
//   - PSR bit positions within the 5-bit {C,L,F,Z,N} vector
//   - ALU opcode constants used by the execute stage
//   - FSM state type for the condition request/response handshake
package cpu_defs;

  // PSR bit indices, vector order {C,L,F,Z,N}
  localparam int PSR_C = 4;
  localparam int PSR_L = 3;
  localparam int PSR_F = 2;
  localparam int PSR_Z = 1;
  localparam int PSR_N = 0;

  localparam int PSR_W = 5;

  typedef enum logic [3:0] {
    COND_EQ = 4'h0,  // Z
    COND_NE = 4'h1,  // ~Z
    COND_CS = 4'h2,  // C
    COND_CC = 4'h3,  // ~C
    COND_HI = 4'h4,  // L
    COND_LS = 4'h5,  // ~L
    COND_GT = 4'h6,  // N
    COND_LE = 4'h7,  // ~N
    COND_FS = 4'h8,  // F
    COND_FC = 4'h9,  // ~F
    COND_LO = 4'hA,  // ~L & ~Z
    COND_HS = 4'hB,  // L | Z
    COND_LT = 4'hC,  // ~N & ~Z
    COND_GE = 4'hD,  // N | Z
    COND_UC = 4'hE,  // always
    COND_NV = 4'hF   // never
  } cond_e;

  // ALU opcode constants (execute-stage encodings)
  localparam logic [3:0] ALU_ADD  = 4'h0;
  localparam logic [3:0] ALU_ADDC = 4'h1;
  localparam logic [3:0] ALU_SUB  = 4'h2;
  localparam logic [3:0] ALU_SUBC = 4'h3;
  localparam logic [3:0] ALU_CMP  = 4'h4;
  localparam logic [3:0] ALU_AND  = 4'h5;
  localparam logic [3:0] ALU_OR   = 4'h6;
  localparam logic [3:0] ALU_XOR  = 4'h7;
  localparam logic [3:0] ALU_NOT  = 4'h8;
  localparam logic [3:0] ALU_MOV  = 4'h9;
  localparam logic [3:0] ALU_LSH  = 4'hA;
  localparam logic [3:0] ALU_ASH  = 4'hB;

  // Condition handshake FSM states
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } fcu_state_e;

endpackage

// File: rtl/cond_eval.sv
// Combinational condition evaluator.
// Maps a 4-bit condition code and the 5 PSR flags {C,L,F,Z,N} to a
// single taken bit. Shared by the branch resolver and the Scond datapath.
// Ports:
//   cond   in  4  condition code
//   flags  in  5  flags {C,L,F,Z,N}
//   taken  out 1  condition true
module cond_eval
  import cpu_defs::*;
(
  input  logic [3:0]       cond,
  input  logic [PSR_W-1:0] flags,
  output logic             taken
);

  logic f_c, f_l, f_f, f_z, f_n;

  assign f_c = flags[PSR_C];
  assign f_l = flags[PSR_L];
  assign f_f = flags[PSR_F];
  assign f_z = flags[PSR_Z];
  assign f_n = flags[PSR_N];

  always_comb begin
    taken = 1'b0;
    case (cond_e'(cond))
      COND_EQ: taken = f_z;
      COND_NE: taken = ~f_z;
      COND_CS: taken = f_c;
      COND_CC: taken = ~f_c;
      COND_HI: taken = f_l;
      COND_LS: taken = ~f_l;
      COND_GT: taken = f_n;
      COND_LE: taken = ~f_n;
      COND_FS: taken = f_f;
      COND_FC: taken = ~f_f;
      COND_LO: taken = ~f_l & ~f_z;
      COND_HS: taken = f_l | f_z;
      COND_LT: taken = ~f_n & ~f_z;
      COND_GE: taken = f_n | f_z;
      COND_UC: taken = 1'b1;
      COND_NV: taken = 1'b0;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/flag_cond_unit.sv
// Processor status flag register and branch-condition resolver.
// Latches ALU flags (masked) or a software PSR write, feeds PSR.C back as
// the ALU carry-in, and resolves condition codes over a valid/ready request
// and valid/ack response handshake with a fixed one-cycle latency.
//
// Ports:
//   clk          in   1  system clock, rising edge
//   reset        in   1  synchronous active-low reset
//   FLAG_VALID   in   1  ALU op completing; latch masked flags
//   FLAG_MASK    in   5  per-flag update enable {C,L,F,Z,N}
//   CARRY_IN     in   1  ALU carry
//   LOW_IN       in   1  ALU low
//   OVF_IN       in   1  ALU overflow (PSR F)
//   ZERO_IN      in   1  ALU zero
//   NEG_IN       in   1  ALU negative
//   PSR_WE       in   1  software PSR write
//   PSR_WDATA    in   5  write data {C,L,F,Z,N}
//   COND_VALID   in   1  condition request valid
//   COND         in   4  condition code
//   COND_READY   out  1  request accepted when COND_VALID & COND_READY
//   TAKEN_VALID  out  1  resolution available
//   TAKEN        out  1  condition true
//   TAKEN_ACK    in   1  controller consumed resolution
//   PSR          out  5  current flags {C,L,F,Z,N}
//   CIN          out  1  PSR.C to ALU carry-in
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_IDLE | no resolution pending; request may be accepted
// ST_HOLD | TAKEN/TAKEN_VALID presented, frozen until TAKEN_ACK
module flag_cond_unit
  import cpu_defs::*;
#(
  parameter bit               FORWARD = 1'b1,
  parameter logic [PSR_W-1:0] PSR_RST = 5'b00000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             FLAG_VALID,
  input  logic [PSR_W-1:0] FLAG_MASK,
  input  logic             CARRY_IN,
  input  logic             LOW_IN,
  input  logic             OVF_IN,
  input  logic             ZERO_IN,
  input  logic             NEG_IN,
  input  logic             PSR_WE,
  input  logic [PSR_W-1:0] PSR_WDATA,
  input  logic             COND_VALID,
  input  logic [3:0]       COND,
  output logic             COND_READY,
  output logic             TAKEN_VALID,
  output logic             TAKEN,
  input  logic             TAKEN_ACK,
  output logic [PSR_W-1:0] PSR,
  output logic             CIN
);

  fcu_state_e       state_q, state_d;
  logic [PSR_W-1:0] psr_q, psr_d;
  logic [PSR_W-1:0] alu_flags;
  logic [PSR_W-1:0] eval_flags;
  logic             taken_q, taken_d;
  logic             tvalid_q, tvalid_d;
  logic             eval_taken;
  logic             psr_busy;
  logic             accept;

  assign alu_flags = {CARRY_IN, LOW_IN, OVF_IN, ZERO_IN, NEG_IN};
  assign psr_busy  = FLAG_VALID | PSR_WE;

  // Software write overrides the ALU completely; ALU only touches masked bits.
  always_comb begin
    psr_d = psr_q;
    if (PSR_WE) begin
      psr_d = PSR_WDATA;
    end else if (FLAG_VALID) begin
      psr_d = (psr_q & ~FLAG_MASK) | (alu_flags & FLAG_MASK);
    end
  end

  // With forwarding, a request that coincides with a flag update sees the
  // value the PSR is about to take. Without it the request is stalled in
  // that cycle, so the registered PSR is always the right source.
  assign eval_flags = FORWARD ? psr_d : psr_q;

  cond_eval u_cond_eval (
    .cond  (COND),
    .flags (eval_flags),
    .taken (eval_taken)
  );

  assign COND_READY = (state_q == ST_IDLE) && (FORWARD || !psr_busy);
  assign accept     = COND_VALID && COND_READY;

  always_comb begin
    state_d  = state_q;
    taken_d  = taken_q;
    tvalid_d = tvalid_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d  = ST_HOLD;
          taken_d  = eval_taken;
          tvalid_d = 1'b1;
        end
      end
      ST_HOLD: begin
        // The ack cycle never accepts a new request: one bubble between
        // resolutions. TAKEN is cleared so it only reads high while valid.
        if (TAKEN_ACK) begin
          state_d  = ST_IDLE;
          taken_d  = 1'b0;
          tvalid_d = 1'b0;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        taken_d  = 1'b0;
        tvalid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      psr_q    <= PSR_RST;
      taken_q  <= 1'b0;
      tvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      psr_q    <= psr_d;
      taken_q  <= taken_d;
      tvalid_q <= tvalid_d;
    end
  end

  assign TAKEN_VALID = tvalid_q;
  assign TAKEN       = taken_q;
  assign PSR         = psr_q;
  // Carry-in always comes from the register, never the forwarded value.
  assign CIN         = psr_q[PSR_C];

endmodule

// File: tb/tb_flag_cond_unit.sv
module tb_flag_cond_unit;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       FLAG_VALID = 1'b0;
  logic [4:0] FLAG_MASK = '0;
  logic       CARRY_IN = 1'b0, LOW_IN = 1'b0, OVF_IN = 1'b0, ZERO_IN = 1'b0, NEG_IN = 1'b0;
  logic       PSR_WE = 1'b0;
  logic [4:0] PSR_WDATA = '0;
  logic       COND_VALID = 1'b0;
  logic [3:0] COND = '0;
  logic       TAKEN_ACK = 1'b0;

  logic       rdy1, tv1, tk1, cin1;
  logic [4:0] psr1;
  logic       rdy0, tv0, tk0, cin0;
  logic [4:0] psr0;

  int ntest = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  flag_cond_unit #(.FORWARD(1'b1), .PSR_RST(5'b00000)) dut1 (
    .clk(clk), .reset(reset), .FLAG_VALID(FLAG_VALID), .FLAG_MASK(FLAG_MASK),
    .CARRY_IN(CARRY_IN), .LOW_IN(LOW_IN), .OVF_IN(OVF_IN), .ZERO_IN(ZERO_IN),
    .NEG_IN(NEG_IN), .PSR_WE(PSR_WE), .PSR_WDATA(PSR_WDATA),
    .COND_VALID(COND_VALID), .COND(COND), .COND_READY(rdy1),
    .TAKEN_VALID(tv1), .TAKEN(tk1), .TAKEN_ACK(TAKEN_ACK), .PSR(psr1), .CIN(cin1)
  );

  flag_cond_unit #(.FORWARD(1'b0), .PSR_RST(5'b00000)) dut0 (
    .clk(clk), .reset(reset), .FLAG_VALID(FLAG_VALID), .FLAG_MASK(FLAG_MASK),
    .CARRY_IN(CARRY_IN), .LOW_IN(LOW_IN), .OVF_IN(OVF_IN), .ZERO_IN(ZERO_IN),
    .NEG_IN(NEG_IN), .PSR_WE(PSR_WE), .PSR_WDATA(PSR_WDATA),
    .COND_VALID(COND_VALID), .COND(COND), .COND_READY(rdy0),
    .TAKEN_VALID(tv0), .TAKEN(tk0), .TAKEN_ACK(TAKEN_ACK), .PSR(psr0), .CIN(cin0)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    ntest++;
    if (obs !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Condition truth table written directly from the flag names.
  function automatic bit ref_cond(input int code, input logic [4:0] p);
    bit c, l, f, z, n;
    c = p[4]; l = p[3]; f = p[2]; z = p[1]; n = p[0];
    case (code)
      0: return z;          1: return !z;
      2: return c;          3: return !c;
      4: return l;          5: return !l;
      6: return n;          7: return !n;
      8: return f;          9: return !f;
      10: return !l && !z;  11: return l || z;
      12: return !n && !z;  13: return n || z;
      14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Reference model, index 0 = no forwarding, 1 = forwarding.
  logic [4:0] m_psr  [2] = '{5'b0, 5'b0};
  bit         m_pend [2] = '{1'b0, 1'b0};
  bit         m_tk   [2] = '{1'b0, 1'b0};

  function automatic logic [4:0] next_flags(input logic [4:0] cur);
    logic [4:0] alu;
    logic [4:0] r;
    alu = {CARRY_IN, LOW_IN, OVF_IN, ZERO_IN, NEG_IN};
    r = cur;
    if (PSR_WE) r = PSR_WDATA;
    else if (FLAG_VALID)
      for (int b = 0; b < 5; b++) if (FLAG_MASK[b]) r[b] = alu[b];
    return r;
  endfunction

  function automatic bit model_ready(input int f);
    if (m_pend[f]) return 1'b0;
    if (f == 0 && (FLAG_VALID || PSR_WE)) return 1'b0;
    return 1'b1;
  endfunction

  always @(posedge clk) begin
    for (int f = 0; f < 2; f++) begin
      logic [4:0] nf;
      bit rdy;
      nf  = next_flags(m_psr[f]);
      rdy = model_ready(f);
      if (!reset) begin
        m_psr[f] = 5'b0; m_pend[f] = 1'b0; m_tk[f] = 1'b0;
      end else begin
        if (rdy && COND_VALID) begin
          m_pend[f] = 1'b1;
          m_tk[f]   = ref_cond(int'(COND), (f == 1) ? nf : m_psr[f]);
        end else if (m_pend[f] && TAKEN_ACK) begin
          m_pend[f] = 1'b0;
          m_tk[f]   = 1'b0;
        end
        m_psr[f] = nf;
      end
    end
  end

  task automatic check_regs();
    chk("psr1", {3'b0, psr1}, {3'b0, m_psr[1]});
    chk("cin1", {7'b0, cin1}, {7'b0, m_psr[1][4]});
    chk("tvalid1", {7'b0, tv1}, {7'b0, m_pend[1]});
    chk("taken1", {7'b0, tk1}, {7'b0, m_tk[1]});
    chk("psr0", {3'b0, psr0}, {3'b0, m_psr[0]});
    chk("tvalid0", {7'b0, tv0}, {7'b0, m_pend[0]});
    chk("taken0", {7'b0, tk0}, {7'b0, m_tk[0]});
  endtask

  task automatic check_ready();
    chk("ready1", {7'b0, rdy1}, {7'b0, model_ready(1)});
    chk("ready0", {7'b0, rdy0}, {7'b0, model_ready(0)});
  endtask

  task automatic tick();
    #1;
    check_ready();
    @(posedge clk);
    #1;
    check_regs();
  endtask

  task automatic idle();
    reset = 1'b1; FLAG_VALID = 1'b0; FLAG_MASK = '0;
    {CARRY_IN, LOW_IN, OVF_IN, ZERO_IN, NEG_IN} = '0;
    PSR_WE = 1'b0; PSR_WDATA = '0; COND_VALID = 1'b0; COND = '0; TAKEN_ACK = 1'b0;
  endtask

  task automatic set_psr(input logic [4:0] v);
    idle(); PSR_WE = 1'b1; PSR_WDATA = v; tick(); PSR_WE = 1'b0;
  endtask

  task automatic ack();
    idle(); TAKEN_ACK = 1'b1; tick(); TAKEN_ACK = 1'b0;
  endtask

  initial begin
    // Reset held two cycles
    idle(); reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_psr", {3'b0, psr1}, 8'h00);
    chk("rst_tvalid", {7'b0, tv1}, 8'h00);
    reset = 1'b1;
    #1;
    chk("rst_ready", {7'b0, rdy1}, 8'h01);
    chk("rst_ready0", {7'b0, rdy0}, 8'h01);

    // ALU zero -> PSR 00010, EQ taken, NE not taken
    idle(); FLAG_VALID = 1'b1; FLAG_MASK = 5'b11111; ZERO_IN = 1'b1; tick();
    chk("zero_psr", {3'b0, psr1}, 8'h02);
    idle(); COND_VALID = 1'b1; COND = 4'h0; tick();
    chk("eq_taken", {7'b0, tk1}, 8'h01);
    ack();
    idle(); COND_VALID = 1'b1; COND = 4'h1; tick();
    chk("ne_taken", {7'b0, tk1}, 8'h00);
    chk("ne_tvalid", {7'b0, tv1}, 8'h01);
    ack();

    // Forwarding vs stall on a coincident flag update
    set_psr(5'b00000);
    idle(); FLAG_VALID = 1'b1; FLAG_MASK = 5'b11111; NEG_IN = 1'b1;
    COND_VALID = 1'b1; COND = 4'h6;
    #1;
    chk("fwd_ready1", {7'b0, rdy1}, 8'h01);
    chk("nofwd_ready0", {7'b0, rdy0}, 8'h00);
    tick();
    chk("fwd_gt_taken", {7'b0, tk1}, 8'h01);
    chk("nofwd_tvalid0", {7'b0, tv0}, 8'h00);
    ack();

    // Masked update only touches Z
    set_psr(5'b11111);
    idle(); FLAG_VALID = 1'b1; FLAG_MASK = 5'b00010; tick();
    chk("mask_psr", {3'b0, psr1}, 8'h1D);
    chk("mask_cin", {7'b0, cin1}, 8'h01);

    // PSR_WE beats FLAG_VALID
    idle(); PSR_WE = 1'b1; PSR_WDATA = 5'b10101;
    FLAG_VALID = 1'b1; FLAG_MASK = 5'b11111;
    {CARRY_IN, LOW_IN, OVF_IN, ZERO_IN, NEG_IN} = 5'b01010; tick();
    chk("we_wins_psr", {3'b0, psr1}, 8'h15);

    // HOLD: resolution frozen while flags change
    set_psr(5'b00000);
    idle(); COND_VALID = 1'b1; COND = 4'hE; tick();
    for (int i = 0; i < 5; i++) begin
      idle(); FLAG_VALID = 1'b1; FLAG_MASK = 5'b11111;
      {CARRY_IN, LOW_IN, OVF_IN, ZERO_IN, NEG_IN} = 5'($urandom);
      COND_VALID = 1'b1; COND = 4'hF; tick();
      chk("hold_taken", {7'b0, tk1}, 8'h01);
      chk("hold_tvalid", {7'b0, tv1}, 8'h01);
    end
    ack();
    chk("ack_tvalid", {7'b0, tv1}, 8'h00);
    // Ack cycle bubble, then reset in third hold cycle
    idle(); COND_VALID = 1'b1; COND = 4'hE; tick();
    idle(); tick(); tick();
    reset = 1'b0; tick();
    chk("rst_hold_tvalid", {7'b0, tv1}, 8'h00);
    chk("rst_hold_taken", {7'b0, tk1}, 8'h00);
    idle();

    // Sweep all codes x all PSR values
    for (int code = 0; code < 16; code++) begin
      for (int p = 0; p < 32; p++) begin
        if ($urandom_range(0, 1) == 0) begin
          set_psr(5'(p));
          idle();
        end else begin
          idle(); PSR_WE = 1'b1; PSR_WDATA = 5'(p);
        end
        COND_VALID = 1'b1; COND = 4'(code); tick();
        chk("sweep", {7'b0, tk1}, {7'b0, ref_cond(code, 5'(p))});
        if (code == 15) chk("never", {7'b0, tk1}, 8'h00);
        if (code == 14) chk("always", {7'b0, tk1}, 8'h01);
        ack();
      end
    end

    // Random traffic against the model
    for (int i = 0; i < 1500; i++) begin
      reset      = ($urandom_range(0, 49) != 0);
      FLAG_VALID = ($urandom_range(0, 2) == 0);
      FLAG_MASK  = 5'($urandom);
      {CARRY_IN, LOW_IN, OVF_IN, ZERO_IN, NEG_IN} = 5'($urandom);
      PSR_WE     = ($urandom_range(0, 6) == 0);
      PSR_WDATA  = 5'($urandom);
      COND_VALID = ($urandom_range(0, 1) == 0);
      COND       = 4'($urandom);
      TAKEN_ACK  = ($urandom_range(0, 4) < 2);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", ntest, nfail);
    $finish;
  end

endmodule
